// File: rtl/csr_row_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : csr_row_accum_if                                              |
// | Description: Product stream in / row-sum stream out bundle, csr_row_accum. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface csr_row_accum_if #(
   parameter int WIDTH    = 32,
   parameter int ROW_BITS = 16
) ();
   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    in_prod;
   logic                in_last;
   logic                in_empty;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_sum;
   logic [ROW_BITS-1:0] out_row;
   logic                out_ovf;

   modport master (
      output in_valid, in_prod, in_last, in_empty, out_ready,
      input  in_ready, out_valid, out_sum, out_row, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, in_empty, out_ready,
      output in_ready, out_valid, out_sum, out_row, out_ovf
   );
endinterface
`default_nettype wire

// File: rtl/csr_row_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : csr_row_accum                                                 |
// | Description: Accumulates CSR row products into tagged row sums behind a    |
// |              2-entry output buffer. Define CSR_ACC_SAT_EN for saturation.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module csr_row_accum #(
   parameter int WIDTH    = 32,
   parameter int ROW_BITS = 16
) (
   input  wire                   clk,
   input  wire                   rst_l,
   input  wire                   clear,
   csr_row_accum_if.slave        bus
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [WIDTH-1:0]    r_acc;
   logic                r_ovf;
   logic [ROW_BITS-1:0] r_row_cnt;

   logic [WIDTH-1:0]    r_fifo_sum [2];
   logic [ROW_BITS-1:0] r_fifo_row [2];
   logic                r_fifo_ovf [2];
   logic                r_rd_ptr;
   logic                r_wr_ptr;
   logic [1:0]          r_count;

   logic                w_in_ready;
   logic                w_accept;
   logic                w_pop;
   logic                w_push;
   logic [WIDTH-1:0]    w_push_sum;
   logic                w_push_ovf;
   logic [WIDTH-1:0]    w_acc_nxt;
   logic                w_ovf_nxt;

   logic [WIDTH-1:0]    w_add_raw;
   logic                w_add_ovf;
   logic [WIDTH-1:0]    w_add_sum;

   // Ready depends only on registered occupancy and clear, never on out_ready.
   assign w_in_ready = !clear && (r_count < 2'd2);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_pop      = (r_count != 2'd0) && bus.out_ready;

   assign w_add_raw  = r_acc + bus.in_prod;
   assign w_add_ovf  = (r_acc[WIDTH-1] == bus.in_prod[WIDTH-1]) &&
                       (w_add_raw[WIDTH-1] != r_acc[WIDTH-1]);

`ifdef CSR_ACC_SAT_EN
   localparam logic [WIDTH-1:0] C_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] C_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Both operands share a sign on overflow, so the accumulator sign picks the rail.
   assign w_add_sum = w_add_ovf ? (r_acc[WIDTH-1] ? C_SAT_MIN : C_SAT_MAX)
                                : w_add_raw;
`else
   assign w_add_sum = w_add_raw;
`endif

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_push_sum  = w_add_sum;
      w_push_ovf  = 1'b0;
      w_acc_nxt   = r_acc;
      w_ovf_nxt   = r_ovf;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (bus.in_last) begin
                  w_push     = 1'b1;
                  w_push_sum = bus.in_empty ? '0 : bus.in_prod;
               end else begin
                  w_state_nxt = S_ACCUM;
                  w_acc_nxt   = bus.in_prod;
                  w_ovf_nxt   = 1'b0;
               end
            end
         end
         S_ACCUM: begin
            if (w_accept) begin
               if (bus.in_last) begin
                  w_state_nxt = S_IDLE;
                  w_push      = 1'b1;
                  w_push_sum  = w_add_sum;
                  w_push_ovf  = r_ovf | w_add_ovf;
               end else begin
                  w_acc_nxt = w_add_sum;
                  w_ovf_nxt = r_ovf | w_add_ovf;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_acc_nxt   = '0;
         w_ovf_nxt   = 1'b0;
         w_push      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_row_cnt <= '0;
      end else begin
         r_acc <= w_acc_nxt;
         r_ovf <= w_ovf_nxt;
         if (clear) begin
            r_row_cnt <= '0;
         end else if (w_push) begin
            r_row_cnt <= r_row_cnt + 1'b1;
         end
      end
   end

   // Entries are zeroed on clear so the idle head matches the reset view.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_sum[i] <= '0;
            r_fifo_row[i] <= '0;
            r_fifo_ovf[i] <= 1'b0;
         end
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (clear) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_sum[i] <= '0;
            r_fifo_row[i] <= '0;
            r_fifo_ovf[i] <= 1'b0;
         end
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo_sum[r_wr_ptr] <= w_push_sum;
            r_fifo_row[r_wr_ptr] <= r_row_cnt;
            r_fifo_ovf[r_wr_ptr] <= w_push_ovf;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_count != 2'd0);
   assign bus.out_sum   = r_fifo_sum[r_rd_ptr];
   assign bus.out_row   = r_fifo_row[r_rd_ptr];
   assign bus.out_ovf   = r_fifo_ovf[r_rd_ptr];

endmodule
`default_nettype wire
